mem_bus_unit: RTL and testbench
===============================

MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of bus, MDR and memory data.
REQ-002 SHALL have parameter ADDR_W, default 9, width of MAR and memory address.
REQ-003 SHALL have parameter TIMEOUT, default 15, number of un-acked ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port bus_in  input  DATA_W  internal bus (MuxOut).
REQ-007 SHALL have port MAR_enable  input  1  load MAR from bus_in[ADDR_W-1:0].
REQ-008 SHALL have port MDR_enable  input  1  load MDR from bus_in.
REQ-009 SHALL have port Read  input  1  start memory read into MDR.
REQ-010 SHALL have port Write  input  1  start memory write of MDR to address MAR.
REQ-011 SHALL have port mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1.
REQ-012 SHALL have port mem_ack  input  1  memory completion strobe.
REQ-013 SHALL have port mem_addr  output  ADDR_W  equals MAR.
REQ-014 SHALL have port mem_wdata  output  DATA_W  equals MDR.
REQ-015 SHALL have port mem_req  output  1  transaction request, registered.
REQ-016 SHALL have port mem_we  output  1  1 = write transaction, registered, valid while mem_req=1.
REQ-017 SHALL have port MDR_data_out  output  DATA_W  MDR contents to bus mux.
REQ-018 SHALL have port busy  output  1  high when state is not IDLE.
REQ-019 SHALL have port done  output  1  one-cycle completion pulse.
REQ-020 SHALL have port error  output  1  one-cycle timeout pulse, coincident with done.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-022 In IDLE, MAR_enable SHALL load MAR; MDR_enable with Read=0 SHALL load MDR; both may occur in the same cycle.
REQ-023 In IDLE, Read=1 SHALL go to ACCESS with mem_req=1, mem_we=0 from the next cycle; Write=1 (Read=0) SHALL do the same with mem_we=1.
REQ-024 Read and Write both high in IDLE: the read SHALL be performed; the write is dropped.
REQ-025 MAR_enable, MDR_enable, Read and Write SHALL be ignored while busy=1.
REQ-026 In ACCESS, mem_ack=1 SHALL end the transaction: a read loads MDR from mem_rdata at that edge; the next state is DONE; mem_req falls.
REQ-027 In ACCESS, a cycle counter SHALL reset on entry and increment each cycle without mem_ack.
REQ-028 If TIMEOUT>0 and TIMEOUT consecutive ACCESS cycles pass without ack, the unit SHALL go to DONE with error=1, leave MDR unchanged and drop mem_req.
REQ-029 An ack in the final (TIMEOUT-th) cycle SHALL win over the timeout, giving normal completion with error=0.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE; commands in DONE are ignored.
REQ-031 mem_ack in IDLE or DONE SHALL be ignored.
REQ-032 Minimum latency: Read/Write sampled at edge N, mem_req high in cycle N+1, ack sampled at edge N+1, done high in cycle N+2, new command accepted at edge N+3.
REQ-033 MDR_data_out SHALL reflect a read result from the cycle after the acking edge.
REQ-034 The counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, minimum 1, and SHALL NOT wrap.

Reset
REQ-035 While reset=0, the unit SHALL asynchronously force state=IDLE, MAR=0, MDR=0, counter=0, mem_req=0, mem_we=0, busy=0, done=0, error=0.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transaction immediately without a done or error pulse.

Verification
REQ-037 Read: MAR_enable with bus_in=0x4B, then Read; ack with mem_rdata=0xDEADBEEF on the first ACCESS cycle -> mem_addr=0x04B, MDR=0xDEADBEEF, done in cycle N+2, error=0.
REQ-038 Write: load MDR=0x00000067 and MAR=0x90, then Write; ack after 3 cycles -> mem_we=1 and mem_wdata=0x67 throughout, done once, MDR unchanged.
REQ-039 Timeout: TIMEOUT=15, Read with no ack -> mem_req high exactly 15 cycles, then done=error=1 for one cycle, MDR unchanged.
REQ-040 Boundary: ack in the 15th ACCESS cycle -> normal completion with error=0; Read+Write together -> mem_we=0.
REQ-041 Busy: MAR_enable/MDR_enable pulses during ACCESS -> MAR/MDR unchanged; reset=0 mid-ACCESS -> mem_req=0 with no clock edge, no done pulse.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Purpose: memory bus interface unit. It holds MAR/MDR and runs a single read
//          or write handshake (mem_req/mem_ack) per command, with an optional timeout.
// Latency: a command sampled at edge N raises mem_req in cycle N+1. The earliest
//          done pulse is in cycle N+2, and the next command is accepted at edge N+3.
// Backpressure: commands and register loads are ignored while busy. mem_req
//          stays high until mem_ack arrives or TIMEOUT un-acked cycles elapse.
//
// Ports:
//   clk, reset (async, active-low)
//   bus_in, MAR_enable, MDR_enable       - register loads from the internal bus (IDLE only)
//   Read, Write                          - start a transaction (Read wins if both are set)
//   mem_rdata, mem_ack                   - memory response
//   mem_addr, mem_wdata, mem_req, mem_we - memory request side
//   MDR_data_out                         - MDR contents back to the bus mux
//   busy, done, error                    - status; done/error are one-cycle pulses

module mem_bus_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_enable,
  input  logic              MDR_enable,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] MDR_data_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The timeout fires when the cycle that brings the count to TIMEOUT also has no ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  mar;
  logic [DATA_W-1:0]  mdr;
  logic [CNT_W-1:0]   cnt;
  logic               start_rd, start_wr, ack_hit, to_hit;

  // Next-state and transaction events
  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Read) begin
          start_rd  = 1'b1;
          state_nxt = S_ACCESS;
        end else if (Write) begin
          start_wr  = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // An ack in the last allowed cycle beats the timeout.
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request flags and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == S_ACCESS);
      done    <= (state_nxt == S_DONE);
      error   <= to_hit;

      if (start_rd || start_wr) begin
        mem_we <= start_wr;
      end else if (state_nxt != S_ACCESS) begin
        mem_we <= 1'b0;
      end

      // The count saturates instead of wrapping; this only matters when TIMEOUT is 0.
      if (start_rd || start_wr) begin
        cnt <= '0;
      end else if ((state == S_ACCESS) && !mem_ack && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // MAR / MDR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if ((state == S_IDLE) && MAR_enable) begin
        mar <= bus_in[ADDR_W-1:0];
      end
      // A read issued in the same cycle owns MDR, so the bus load is suppressed.
      if ((state == S_IDLE) && MDR_enable && !Read) begin
        mdr <= bus_in;
      end else if (ack_hit && !mem_we) begin
        mdr <= mem_rdata;
      end
    end
  end

  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign MDR_data_out = mdr;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_unit.sv
// Purpose: self-checking bench for mem_bus_unit. It drives directed and random
//          transactions against a transaction-level model of MAR, MDR and timing.
// Latency: checks mem_req in the cycle after the command edge and the done pulse
//          in the cycle after the ack or timeout edge.
// Backpressure: drives noise on the command and load inputs while busy and expects it to be ignored.

module tb_mem_bus_unit;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] bus_in;
  logic          MAR_enable, MDR_enable, Read, Write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req, mem_we;
  logic [DW-1:0] MDR_data_out;
  logic          busy, done, error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction-level model state
  logic [AW-1:0] mar_m;
  logic [DW-1:0] mdr_m;

  mem_bus_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .Read(Read), .Write(Write),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .MDR_data_out(MDR_data_out),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_in     = '0;
    MAR_enable = 1'b0;
    MDR_enable = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
  endtask

  // Random junk on every control input; the DUT must ignore it while busy.
  task automatic drive_noise();
    bus_in     = $urandom;
    MAR_enable = 1'($urandom_range(0, 1));
    MDR_enable = 1'($urandom_range(0, 1));
    Read       = 1'($urandom_range(0, 1));
    Write      = 1'($urandom_range(0, 1));
    mem_ack    = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".addr"}, 64'(mem_addr), 64'(mar_m));
    check({tag, ".mdr"},  64'(MDR_data_out), 64'(mdr_m));
    check({tag, ".wdat"}, 64'(mem_wdata), 64'(mdr_m));
  endtask

  // op: 0 = Read, 1 = Write, 2 = Read and Write together.
  // delay: ack arrives in ACCESS cycle delay+1; delay >= TO means no ack before the timeout.
  task automatic txn(input bit mdr_en, input logic [DW-1:0] mdr_val,
                     input bit mar_en, input logic [DW-1:0] mar_val,
                     input bit cmd_mdr_en, input logic [DW-1:0] cmd_val,
                     input int op, input int delay,
                     input logic [DW-1:0] rdata, input bit noise);
    bit rd;
    bit err;
    int n;
    rd  = (op != 1);
    err = (delay >= TO);
    n   = err ? TO : delay + 1;

    // Load MDR. A stray ack in IDLE must be ignored.
    clear_inputs();
    MDR_enable = mdr_en;
    bus_in     = mdr_val;
    if (noise) mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'(0));
    check("idle.req",  64'(mem_req), 64'(0));
    step();
    if (mdr_en) mdr_m = mdr_val;

    // Load MAR.
    clear_inputs();
    MAR_enable = mar_en;
    bus_in     = mar_val;
    step();
    if (mar_en) mar_m = mar_val[AW-1:0];

    // Issue the command. An MDR load alongside a read is suppressed.
    clear_inputs();
    Read       = rd;
    Write      = (op != 0);
    MDR_enable = cmd_mdr_en;
    bus_in     = cmd_val;
    step();
    if (cmd_mdr_en && !rd) mdr_m = cmd_val;

    // ACCESS: mem_req must hold for exactly n cycles.
    for (int k = 1; k <= n; k++) begin
      clear_inputs();
      if (noise) drive_noise();
      mem_ack   = (k == delay + 1);
      mem_rdata = (k == delay + 1) ? rdata : DW'($urandom);
      @(negedge clk);
      check("acc.req",  64'(mem_req), 64'(1));
      check("acc.we",   64'(mem_we), 64'(op == 1));
      check("acc.busy", 64'(busy), 64'(1));
      check("acc.done", 64'(done), 64'(0));
      check_regs("acc");
      step();
    end
    if (rd && !err) mdr_m = rdata;

    // DONE: exactly one cycle; commands and acks are ignored.
    clear_inputs();
    if (noise) drive_noise();
    @(negedge clk);
    check("done.done", 64'(done), 64'(1));
    check("done.err",  64'(error), 64'(err));
    check("done.req",  64'(mem_req), 64'(0));
    check("done.busy", 64'(busy), 64'(1));
    check_regs("done");
    step();

    // Back to IDLE.
    clear_inputs();
    @(negedge clk);
    check("post.done", 64'(done), 64'(0));
    check("post.err",  64'(error), 64'(0));
    check("post.busy", 64'(busy), 64'(0));
    check_regs("post");
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    mar_m = '0;
    mdr_m = '0;
    #12;
    check("rst.req",  64'(mem_req), 64'(0));
    check("rst.we",   64'(mem_we), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.err",  64'(error), 64'(0));
    check_regs("rst");
    step();
    reset = 1'b1;
    step();

    // Read at 0x4B, acked in the first ACCESS cycle.
    txn(0, 0, 1, 32'h4B, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    // Write of 0x67 to 0x90, acked after 3 cycles.
    txn(1, 32'h67, 1, 32'h90, 0, 0, 1, 3, 32'h12345678, 0);
    // Timeout: no ack. MDR must stay unchanged.
    txn(0, 0, 0, 0, 0, 0, 0, TO + 5, 32'hCAFEF00D, 0);
    // Ack in the 15th cycle wins over the timeout.
    txn(0, 0, 1, 32'h1FF, 0, 0, 0, TO - 1, 32'hA5A5A5A5, 0);
    // Read and Write together: the read wins. The MDR load in the command cycle is dropped.
    txn(1, 32'h11, 1, 32'h22, 1, 32'h33, 2, 1, 32'h55AA55AA, 1);
    // Write with an MDR load in the command cycle: the new MDR value is written.
    txn(0, 0, 1, 32'h7, 1, 32'hBEEF0001, 1, 0, 32'h0, 1);

    // Random transactions with noise while busy.
    for (int t = 0; t < 60; t++) begin
      txn(1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 2), $urandom_range(0, TO + 2),
          $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ACCESS aborts with no edge and no done pulse.
    clear_inputs();
    MAR_enable = 1'b1;
    bus_in     = 32'h0AB;
    step();
    clear_inputs();
    Read = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    check("mid.req_before", 64'(mem_req), 64'(1));
    reset = 1'b0;
    #1;
    mar_m = '0;
    mdr_m = '0;
    check("mid.req",  64'(mem_req), 64'(0));
    check("mid.busy", 64'(busy), 64'(0));
    check("mid.done", 64'(done), 64'(0));
    check("mid.err",  64'(error), 64'(0));
    check_regs("mid");
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid.nodone", 64'(done), 64'(0));
      check("mid.idle",   64'(busy), 64'(0));
    end
    step();
    // The unit must still work after the abort.
    txn(1, 32'h5, 1, 32'h3, 0, 0, 0, 2, 32'h0BADC0DE, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
